bcd_to_excess3_serial: RTL and testbench

Bit-serial BCD-to-Excess-3 converter; the inverse of the team's serial Excess-3-to-BCD converter.
- One BCD digit arrives on X as 4 consecutive bits, LSB first, one bit per Clk cycle.
- The matching Excess-3 bit (BCD + 3) is produced on Z in the same cycle (Mealy output).
- Also flags non-BCD input digits (10..15), marks digit boundaries, and counts valid digits converted.
- Sits on the serial digit link, feeding a downstream Excess-3 consumer.

---
 rtl/bcd_to_excess3_serial.sv | 101 ++++++++++
 tb/tb_bcd_to_excess3_serial.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_excess3_serial.sv
// Bit-serial BCD to Excess-3 converter.
// Digits arrive LSB first, one bit per clock, back-to-back. Z is the matching
// Excess-3 bit in the same cycle (serial add of 0011). Digits above 9 raise Err
// on their last bit; ValidCnt counts completed in-range digits and saturates.
module bcd_to_excess3_serial #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             X,
  output logic             Z,
  output logic [1:0]       BitPos,
  output logic             DigitDone,
  output logic             Err,
  output logic [CNT_W-1:0] ValidCnt
);

  // State encoding is {bit position[1:0], carry, aux}; aux holds b1 in the
  // B2 states and h = b1 | b2 in the B3 states, unused (0) elsewhere.
  typedef enum logic [3:0] {
    B0       = 4'b0000,
    B1_C0    = 4'b0100,
    B1_C1    = 4'b0110,
    B2_C0B0  = 4'b1000,
    B2_C0B1  = 4'b1001,
    B2_C1B0  = 4'b1010,
    B2_C1B1  = 4'b1011,
    B3_C0H0  = 4'b1100,
    B3_C0H1  = 4'b1101,
    B3_C1H0  = 4'b1110,
    B3_C1H1  = 4'b1111
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] pos;
  logic       carry;
  logic       aux;

  assign pos   = state[3:2];
  assign carry = state[1];
  assign aux   = state[0];

  // State register; reset abandons any partial digit.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= B0;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: advance bit position, update carry and range tracking.
  always_comb begin
    state_nxt = B0;
    unique case (pos)
      2'd0: state_nxt = state_t'({2'd1, X, 1'b0});
      2'd1: state_nxt = state_t'({2'd2, X | carry, X});
      2'd2: state_nxt = state_t'({2'd3, X & carry, aux | X});
      2'd3: state_nxt = B0;
      default: state_nxt = B0;
    endcase
  end

  // Mealy outputs: serial sum bit, digit boundary and range error, all held
  // low while reset is asserted.
  always_comb begin
    Z         = 1'b0;
    DigitDone = 1'b0;
    Err       = 1'b0;
    BitPos    = pos;
    unique case (pos)
      2'd0: Z = ~X;
      2'd1: Z = X ^ ~carry;
      2'd2: Z = X ^ carry;
      2'd3: begin
        Z         = X ^ carry;
        DigitDone = 1'b1;
        Err       = X & aux;
      end
      default: Z = 1'b0;
    endcase
    if (!Rst) begin
      Z         = 1'b0;
      DigitDone = 1'b0;
      Err       = 1'b0;
    end
  end

  // Saturating count of digits completed without a range error.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ValidCnt <= '0;
    end else if (DigitDone && !Err && (ValidCnt != CNT_MAX)) begin
      ValidCnt <= ValidCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bcd_to_excess3_serial.sv
// Self-checking bench for bcd_to_excess3_serial: directed literal digits,
// asynchronous reset mid-digit, counter saturation on a narrow instance, and a
// long randomized run compared against a digit-level arithmetic model.
module tb_bcd_to_excess3_serial;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CNT_W2 = 2;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              X;
  logic              Z, Z2;
  logic [1:0]        BitPos, BitPos2;
  logic              DigitDone, DigitDone2;
  logic              Err, Err2;
  logic [CNT_W-1:0]  ValidCnt;
  logic [CNT_W2-1:0] ValidCnt2;

  int total = 0;
  int bad   = 0;

  // Model state (digit-level): bit index, bits collected so far, counts.
  int m_pos   = 0;
  int m_bits  = 0;
  int m_zbits = 0;
  int m_cnt   = 0;
  int m_cnt2  = 0;
  int valid_done = 0;

  bcd_to_excess3_serial #(.CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst), .X(X), .Z(Z), .BitPos(BitPos),
    .DigitDone(DigitDone), .Err(Err), .ValidCnt(ValidCnt)
  );

  bcd_to_excess3_serial #(.CNT_W(CNT_W2)) dut2 (
    .Clk(Clk), .Rst(Rst), .X(X), .Z(Z2), .BitPos(BitPos2),
    .DigitDone(DigitDone2), .Err(Err2), .ValidCnt(ValidCnt2)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the arithmetic model.
  always @(negedge Clk) begin
    int partial;
    int ez;
    bit eerr;
    if (!Rst) begin
      check("rst_z", 32'(Z), 0);
      check("rst_dd", 32'(DigitDone), 0);
      check("rst_err", 32'(Err), 0);
      check("rst_bitpos", 32'(BitPos), 0);
      check("rst_cnt", 32'(ValidCnt), 0);
      check("rst_cnt2", 32'(ValidCnt2), 0);
      m_pos = 0; m_bits = 0; m_zbits = 0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      partial = m_bits | (int'(X) << m_pos);
      // Low sum bits depend only on the low addend bits seen so far.
      ez   = ((partial + 3) >> m_pos) & 1;
      eerr = (m_pos == 3) && (partial > 9);
      check("m_z", 32'(Z), 32'(ez));
      check("m_z2", 32'(Z2), 32'(ez));
      check("m_bitpos", 32'(BitPos), 32'(m_pos));
      check("m_bitpos2", 32'(BitPos2), 32'(m_pos));
      check("m_dd", 32'(DigitDone), 32'(m_pos == 3));
      check("m_dd2", 32'(DigitDone2), 32'(m_pos == 3));
      check("m_err", 32'(Err), 32'(eerr));
      check("m_err2", 32'(Err2), 32'(eerr));
      check("m_cnt", 32'(ValidCnt), 32'(m_cnt));
      check("m_cnt2", 32'(ValidCnt2), 32'(m_cnt2));
      m_zbits = m_zbits | (int'(Z) << m_pos);
      if (m_pos == 3) begin
        check("m_zdigit", 32'(m_zbits), 32'((partial + 3) % 16));
        if (partial <= 9) begin
          m_cnt  = (m_cnt  < 255) ? m_cnt + 1  : 255;
          m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
          valid_done++;
        end
        m_pos = 0; m_bits = 0; m_zbits = 0;
      end else begin
        m_pos++;
        m_bits = partial;
      end
    end
  end

  task automatic drive(input logic r, input logic x);
    @(posedge Clk);
    #1;
    Rst = r;
    X   = x;
  endtask

  // Send one digit with hand-computed expectations checked at each negedge.
  task automatic send_digit(input int d, input int ezd, input bit eerr,
                            input int ecnt, input int ecnt2);
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, 1'(d >> b));
      @(negedge Clk);
      #1;
      check($sformatf("lit_z_d%0d_b%0d", d, b), 32'(Z), 32'((ezd >> b) & 1));
      check($sformatf("lit_bitpos_d%0d_b%0d", d, b), 32'(BitPos), 32'(b));
      if (b == 0) begin
        check($sformatf("lit_cnt_d%0d", d), 32'(ValidCnt), 32'(ecnt));
        check($sformatf("lit_cnt2_d%0d", d), 32'(ValidCnt2), 32'(ecnt2));
      end
      if (b == 3) begin
        check($sformatf("lit_dd_d%0d", d), 32'(DigitDone), 1);
        check($sformatf("lit_err_d%0d", d), 32'(Err), 32'(eerr));
      end else begin
        check($sformatf("lit_dd0_d%0d_b%0d", d, b), 32'(DigitDone), 0);
      end
    end
  endtask

  int zt_valid [10] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
  int zt_inv   [6]  = '{13, 14, 15, 0, 1, 2};

  initial begin
    int start_valid;
    int cycles;
    int d;
    bit rs;
    int rb;
    Rst = 1'b0;
    X   = 1'b0;
    repeat (2) @(posedge Clk);

    // BCD 5 -> Excess-3 8.
    send_digit(5, 8, 1'b0, 0, 0);
    // All ten digits back-to-back.
    for (int i = 0; i < 10; i++)
      send_digit(i, zt_valid[i], 1'b0, 1 + i, (1 + i > 3) ? 3 : 1 + i);
    // Invalid digits 10..15: Err raised, counter frozen at 11.
    for (int i = 0; i < 6; i++)
      send_digit(10 + i, zt_inv[i], 1'b1, 11, 3);

    // Two bits of digit 3, then asynchronous reset between edges.
    drive(1'b1, 1'b1);
    @(negedge Clk); #1 check("pre_rst_z_b0", 32'(Z), 0);
    drive(1'b1, 1'b1);
    @(negedge Clk); #1 check("pre_rst_z_b1", 32'(Z), 1);
    @(posedge Clk);
    #3 Rst = 1'b0;
    #1;
    check("async_z", 32'(Z), 0);
    check("async_dd", 32'(DigitDone), 0);
    check("async_err", 32'(Err), 0);
    check("async_bitpos", 32'(BitPos), 0);
    check("async_cnt", 32'(ValidCnt), 0);
    check("async_cnt2", 32'(ValidCnt2), 0);
    @(posedge Clk);

    // After release: 7 -> 10, then saturation of the 2-bit counter.
    send_digit(7, 10, 1'b0, 0, 0);
    send_digit(1, 4, 1'b0, 1, 1);
    send_digit(2, 5, 1'b0, 2, 2);
    send_digit(8, 11, 1'b0, 3, 3);
    send_digit(4, 7, 1'b0, 4, 3);
    send_digit(0, 3, 1'b0, 5, 3);

    // Randomized regression with occasional mid-digit resets.
    start_valid = valid_done;
    cycles = 0;
    while ((valid_done - start_valid < 10000) && (cycles < 90000)) begin
      d  = ($urandom_range(0, 99) < 80) ? int'($urandom_range(0, 9))
                                        : int'($urandom_range(10, 15));
      rs = ($urandom_range(0, 9) == 0);
      rb = int'($urandom_range(0, 3));
      for (int b = 0; b < 4; b++) begin
        if (rs && b == rb) begin
          repeat ($urandom_range(1, 2)) begin
            drive(1'b0, 1'($urandom_range(0, 1)));
            cycles++;
          end
          break;
        end
        drive(1'b1, 1'(d >> b));
        cycles++;
      end
    end
    @(negedge Clk);
    #1;
    check("random_valid_digits", 32'(valid_done - start_valid >= 10000), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #1500000;
    bad++;
    $display("FAIL watchdog: run not finished at %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
